// File: rtl/ahb_ic_pkg.sv
// Shared types for the AHB-lite interconnect: transfer types, interconnect FSM
// states and response encodings.
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ic_state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_ic_if.sv
// Bus bundle between the CPU master, the slaves and the interconnect.
// The master modport is the environment view; the slave modport is the interconnect view.
interface ahb_ic_if #(
  parameter int DWidth   = 32,
  parameter int NumSlave = 4,
  parameter int CntWidth = 8
);
  logic [DWidth-1:0]          addr_i;
  logic [1:0]                 trans_i;
  logic [NumSlave*DWidth-1:0] rdata_i;
  logic [NumSlave-1:0]        resp_i;
  logic [NumSlave-1:0]        readyout_i;
  logic [NumSlave-1:0]        sel_o;
  logic [DWidth-1:0]          rdata_o;
  logic                       resp_o;
  logic                       ready_o;
  logic                       timeout_o;
  logic [CntWidth-1:0]        err_cnt_o;

  modport master (
    output addr_i, trans_i, rdata_i, resp_i, readyout_i,
    input  sel_o, rdata_o, resp_o, ready_o, timeout_o, err_cnt_o
  );

  modport slave (
    input  addr_i, trans_i, rdata_i, resp_i, readyout_i,
    output sel_o, rdata_o, resp_o, ready_o, timeout_o, err_cnt_o
  );
endinterface

// File: rtl/ahb_ic_decoder.sv
// Combinational region decoder: slave k owns region BaseRegion+k.
// A miss yields an all-zero select and hit=0.
module ahb_ic_decoder #(
  parameter int NumSlave   = 4,
  parameter int RegionBits = 4,
  parameter int BaseRegion = 0,
  parameter int IdxW       = 2
) (
  input  logic [RegionBits-1:0] region,
  output logic [NumSlave-1:0]   sel,
  output logic                  hit,
  output logic [IdxW-1:0]       idx
);

  // Compare in 32-bit space so BaseRegion+k beyond the region range never aliases.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NumSlave; k++) begin
      if (32'(region) == 32'(BaseRegion + k)) begin
        sel[k] = 1'b1;
        hit    = 1'b1;
        idx    = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/ahb_interconnect_ext.sv
// Single-master AHB-lite interconnect: address decode, data-phase mux,
// built-in default slave, stall watchdog and saturating error counter.
module ahb_interconnect_ext
  import ahb_ic_pkg::*;
#(
  parameter int DWidth        = 32,
  parameter int NumSlave      = 4,
  parameter int RegionBits    = 4,
  parameter int BaseRegion    = 0,
  parameter int TimeoutCycles = 255,
  parameter int CntWidth      = 8
) (
  input logic    clk_i,
  input logic    rst_ni,
  ahb_ic_if.slave bus
);

  localparam int IdxW = (NumSlave > 1) ? $clog2(NumSlave) : 1;
  localparam int WdW  = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);

  ic_state_t           state, state_next, accept_state;
  logic [IdxW-1:0]     dsel, hit_idx;
  logic [WdW-1:0]      wd_cnt;
  logic [CntWidth-1:0] err_cnt;
  logic                timeout_q;
  logic                hit, active, slave_ready, wd_fire;
  logic                ready, resp;
  logic [DWidth-1:0]   rdata;
  logic                unused_bits;

  assign unused_bits = ^bus.addr_i;

  ahb_ic_decoder #(
    .NumSlave  (NumSlave),
    .RegionBits(RegionBits),
    .BaseRegion(BaseRegion),
    .IdxW      (IdxW)
  ) u_decoder (
    .region(bus.addr_i[DWidth-1 -: RegionBits]),
    .sel   (bus.sel_o),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign active = (trans_t'(bus.trans_i) == TRANS_NONSEQ) ||
                  (trans_t'(bus.trans_i) == TRANS_SEQ);
  assign accept_state = !active ? ST_IDLE : (hit ? ST_DATA : ST_ERR1);
  assign slave_ready  = bus.readyout_i[dsel];
  // A slave going ready on the limit cycle wins over the watchdog.
  assign wd_fire = (state == ST_DATA) && !slave_ready && (wd_cnt == WdMax);

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    resp       = RESP_OKAY;
    rdata      = '0;
    unique case (state)
      ST_IDLE: state_next = accept_state;
      ST_DATA: begin
        ready = slave_ready;
        resp  = bus.resp_i[dsel];
        rdata = bus.rdata_i[dsel*DWidth +: DWidth];
        if (slave_ready) state_next = accept_state;
        else if (wd_fire) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        ready      = 1'b0;
        resp       = RESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        resp       = RESP_ERROR;
        state_next = accept_state;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      dsel      <= '0;
      wd_cnt    <= '0;
      err_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      timeout_q <= wd_fire;
      if (ready) begin
        dsel   <= hit_idx;
        wd_cnt <= '0;
      end else if ((state == ST_DATA) && (wd_cnt != WdMax)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (ready && resp && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.resp_o    = resp;
  assign bus.rdata_o   = rdata;
  assign bus.timeout_o = timeout_q;
  assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_ahb_interconnect_ext.sv
// Scoreboard bench: a driver issues planned/random transfers and pushes the
// transfer-level prediction; a monitor pops it at every completion cycle.
module tb_ahb_interconnect_ext;
  import ahb_ic_pkg::*;

  localparam int DW     = 32;
  localparam int NS     = 4;
  localparam int TO     = 8;
  localparam int CW     = 2;
  localparam int CntMax = (1 << CW) - 1;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          stall;
    bit          err;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    bit          resp;
    logic [31:0] rdata;
    int          waits;
    bit          tmo;
    int          err_before;
  } exp_t;

  logic clk;
  logic rst_n;
  xfer_t plan[$];
  exp_t  exp_q[$];
  xfer_t ap, dp;
  exp_t  mon_e;
  int    p;
  int    checks = 0;
  int    errors = 0;
  int    model_err = 0;
  int    waits = 0;
  bit    to_seen = 0;
  bit    drv_en = 0;
  bit    mon_en = 0;
  logic  rdy_s;

  ahb_ic_if #(.DWidth(DW), .NumSlave(NS), .CntWidth(CW)) bus ();

  ahb_interconnect_ext #(
    .DWidth(DW), .NumSlave(NS), .RegionBits(4), .BaseRegion(0),
    .TimeoutCycles(TO), .CntWidth(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    return int'(a[31:28]);
  endfunction

  function automatic xfer_t make_xfer(input logic [31:0] a, input logic [1:0] t,
                                      input int s, input bit e, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.trans = t; x.stall = s; x.err = e; x.data = d;
    return x;
  endfunction

  function automatic xfer_t filler();
    return make_xfer($urandom, 2'($urandom_range(0, 1)), 0, 1'b0, 32'h0);
  endfunction

  function automatic xfer_t rand_xfer();
    int r, s;
    bit e;
    r = ($urandom_range(0, 9) < 7) ? $urandom_range(0, NS - 1) : $urandom_range(NS, 15);
    s = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 1, TO + 3);
    e = ($urandom_range(0, 4) == 0);
    if (e && s == 0) s = 1;
    return make_xfer({4'(r), 28'($urandom)}, 2'($urandom_range(0, 3)), s, e, $urandom);
  endfunction

  // Transfer-level outcome: waits seen by the master, response, data, watchdog.
  function automatic exp_t predict(input xfer_t x);
    exp_t e;
    int r;
    r = region_of(x.addr);
    e.resp = 1'b0; e.rdata = 32'h0; e.waits = 0; e.tmo = 1'b0; e.err_before = 0;
    if (x.trans[1]) begin
      if (r >= NS) begin
        e.resp = 1'b1; e.waits = 1;
      end else if (x.stall > TO) begin
        e.resp = 1'b1; e.waits = TO + 2; e.tmo = 1'b1;
      end else begin
        e.resp = x.err; e.rdata = x.data; e.waits = x.stall;
      end
    end
    return e;
  endfunction

  function automatic void push_exp(input xfer_t x);
    exp_t e;
    e = predict(x);
    e.err_before = model_err;
    if (e.resp && model_err < CntMax) model_err++;
    exp_q.push_back(e);
  endfunction

  task automatic apply_stimulus();
    int r;
    bus.readyout_i = NS'($urandom);
    bus.resp_i     = NS'($urandom);
    for (int k = 0; k < NS; k++) bus.rdata_i[k*DW +: DW] = $urandom;
    r = region_of(dp.addr);
    if (dp.trans[1] && r < NS) begin
      bus.readyout_i[r]        = (p >= dp.stall);
      bus.resp_i[r]            = dp.err && (p >= dp.stall - 1);
      bus.rdata_i[r*DW +: DW]  = dp.data;
    end
  endtask

  initial forever begin
    @(negedge clk);
    rdy_s = bus.ready_o;
  end

  // Driver: advances the master on acceptance and plays the selected slave.
  initial forever begin
    logic [NS-1:0] es;
    int r;
    @(posedge clk);
    #1;
    if (drv_en) begin
      if (rdy_s) begin
        push_exp(ap);
        dp = ap;
        p  = 0;
        ap = (plan.size() > 0) ? plan.pop_front() : filler();
        bus.addr_i  = ap.addr;
        bus.trans_i = ap.trans;
      end else begin
        p++;
      end
      apply_stimulus();
      #1;
      r  = region_of(ap.addr);
      es = (r < NS) ? NS'(1 << r) : '0;
      check_output("sel", 64'(bus.sel_o), 64'(es));
    end
  end

  // Monitor: every ready cycle completes the oldest outstanding transfer.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      to_seen = to_seen | bus.timeout_o;
      if (!bus.ready_o) begin
        waits++;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL underflow: completion with no outstanding transfer at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("resp",    64'(bus.resp_o),    64'(mon_e.resp));
        check_output("rdata",   64'(bus.rdata_o),   64'(mon_e.rdata));
        check_output("waits",   64'(waits),         64'(mon_e.waits));
        check_output("timeout", 64'(to_seen),       64'(mon_e.tmo));
        check_output("err_cnt", 64'(bus.err_cnt_o), 64'(mon_e.err_before));
        waits   = 0;
        to_seen = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int guard;
    exp_t reset_e;
    bus.addr_i = '0; bus.trans_i = '0; bus.readyout_i = '0; bus.resp_i = '0; bus.rdata_i = '0;
    rst_n = 1'b0;
    dp = make_xfer(32'h0, 2'd0, 0, 1'b0, 32'h0);
    p  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready",   64'(bus.ready_o),   64'(1));
    check_output("rst_resp",    64'(bus.resp_o),    64'(0));
    check_output("rst_rdata",   64'(bus.rdata_o),   64'(0));
    check_output("rst_timeout", 64'(bus.timeout_o), 64'(0));
    check_output("rst_err_cnt", 64'(bus.err_cnt_o), 64'(0));

    plan.push_back(make_xfer(32'h2000_0000, 2'd2, 0,      1'b0, 32'hDEAD_BEEF));
    plan.push_back(make_xfer(32'h1000_0004, 2'd2, 3,      1'b0, 32'h1111_1111));
    plan.push_back(make_xfer(32'h3000_0008, 2'd3, 0,      1'b0, 32'h3333_3333));
    plan.push_back(make_xfer(32'h9000_0000, 2'd2, 0,      1'b0, 32'h0));
    plan.push_back(make_xfer(32'h9000_0000, 2'd0, 0,      1'b0, 32'h0));
    plan.push_back(make_xfer(32'h0000_0010, 2'd2, TO + 1, 1'b0, 32'h0A0A_0A0A));
    plan.push_back(make_xfer(32'h2000_0000, 2'd2, TO,     1'b0, 32'h5A5A_5A5A));
    plan.push_back(make_xfer(32'h1000_0000, 2'd2, 2,      1'b1, 32'h0000_0E77));
    for (int i = 0; i < 5; i++) plan.push_back(make_xfer(32'hF000_0000 | i, 2'd2, 0, 1'b0, 32'h0));
    for (int i = 0; i < 300; i++) plan.push_back(rand_xfer());

    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    ap      = filler();
    bus.addr_i  = ap.addr;
    bus.trans_i = ap.trans;
    model_err = 0;
    reset_e.resp = 1'b0; reset_e.rdata = 32'h0; reset_e.waits = 0; reset_e.tmo = 1'b0; reset_e.err_before = 0;
    exp_q.push_back(reset_e);
    waits = 0; to_seen = 1'b0;
    mon_en = 1'b1;
    drv_en = 1'b1;

    guard = 0;
    while (plan.size() > 0 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (plan.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d transfers left, expected 0", plan.size());
    end
    repeat (TO + 6) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    drv_en = 1'b0;
    check_output("queue_drained", 64'(exp_q.size()), 64'(0));
    check_output("err_before_reset", 64'(bus.err_cnt_o), 64'(model_err));

    @(posedge clk);
    #1;
    bus.addr_i = 32'h0000_0000; bus.trans_i = 2'd2; bus.readyout_i = '0; bus.resp_i = '0;
    @(posedge clk);
    #1;
    bus.trans_i = 2'd0;
    @(negedge clk);
    check_output("stall_ready", 64'(bus.ready_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.addr_i = 32'h3000_0000;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_ready",   64'(bus.ready_o),   64'(1));
    check_output("midrst_resp",    64'(bus.resp_o),    64'(0));
    check_output("midrst_rdata",   64'(bus.rdata_o),   64'(0));
    check_output("midrst_err_cnt", 64'(bus.err_cnt_o), 64'(0));
    check_output("midrst_timeout", 64'(bus.timeout_o), 64'(0));
    check_output("midrst_sel",     64'(bus.sel_o),     64'(4'b1000));
    rst_n = 1'b1;
    bus.addr_i = 32'h1000_0000;
    #1;
    check_output("post_rst_sel", 64'(bus.sel_o), 64'(4'b0010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect_ext.md
Name: ahb_interconnect_ext

Overview:
- Parametrised single-master AHB-lite style bus interconnect. Combines address decode, registered data-phase select, read/response mux, built-in default slave and per-transfer stall watchdog.
- Sits between the CPU master port and NumSlave memory/peripheral slaves.
- Successor to the fixed decoder+mux pair: adds a parameter-driven address map, two-cycle ERROR responses, timeout recovery and an error counter.

Parameters:
- DWidth, 32, address/data width.
- NumSlave, 4, real slaves (1..16); default slave is internal.
- RegionBits, 4, top address bits used for decode.
- BaseRegion, 0, region value of slave 0; slave k owns region BaseRegion+k.
- TimeoutCycles, 255, data-phase wait states before forced ERROR (>=2).
- CntWidth, 8, width of error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- addr_i  in  DWidth  master address (address phase).
- trans_i  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- rdata_i  in  NumSlave*DWidth  slave read data, slave k at bits [k*DWidth +: DWidth].
- resp_i  in  NumSlave  slave resp (1 = ERROR).
- readyout_i  in  NumSlave  slave ready outputs.
- sel_o  out  NumSlave  one-hot address-phase slave select (combinational from addr_i).
- rdata_o  out  DWidth  muxed read data to master.
- resp_o  out  1  response to master.
- ready_o  out  1  ready to master; also fanned out as ready input of all slaves.
- timeout_o  out  1  one-cycle pulse when watchdog fires.
- err_cnt_o  out  CntWidth  saturating count of ERROR responses delivered.

Behaviour:
- Reset (rst_ni=0 at a clock edge): state IDLE, data-phase select = none, ready_o=1, resp_o=0, rdata_o=0, timeout_o=0, err_cnt_o=0, watchdog counter=0.
- Decode: region = addr_i[DWidth-1 -: RegionBits]; hit k when region==BaseRegion+k and k<NumSlave. sel_o is one-hot on hit, all-zero on miss. sel_o is independent of trans_i.
- Address phase: accepted on a clock edge with ready_o=1.
  - At acceptance, register dsel (hit index or DEFAULT) and dactive = trans_i[1].
  - While ready_o=0, dsel and dactive hold.
- FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE: ready_o=1, resp_o=0, rdata_o=0. Accepted NONSEQ/SEQ goes to DATA if hit, or ERR1 if miss. IDLE/BUSY transfers stay in IDLE (zero-wait OKAY).
- DATA: ready_o = readyout_i[dsel], resp_o = resp_i[dsel], rdata_o = rdata_i[dsel].
  - When readyout_i[dsel]=1, the next state is set by the newly accepted address phase, so back-to-back transfers have no bubble.
  - A slave ERROR is passed through unchanged; slaves own their own two-cycle protocol.
- ERR1: ready_o=0, resp_o=1. Always goes to ERR2. The address phase is not accepted in this cycle.
- ERR2: ready_o=1, resp_o=1. The next address phase is accepted and decoded as in IDLE.
- Watchdog:
  - Counter clears on entry to DATA and counts each DATA cycle with readyout_i[dsel]=0.
  - When the counter reaches TimeoutCycles: go to ERR1, pulse timeout_o for 1 cycle, and clear dsel to none.
  - Later readyout_i from the abandoned slave is ignored.
- Error counter: err_cnt_o increments once per ERROR completion (cycle with ready_o=1 and resp_o=1), covering both slave and default/timeout errors. It saturates at all-ones.
- Simultaneous events: if the slave goes ready in the same cycle the counter reaches TimeoutCycles, the slave completion wins and there is no timeout.
- Reset mid-transfer: FSM returns to IDLE next edge; any in-flight transfer is dropped with no response.
- Widths: counters are unsigned. The watchdog counter is $clog2(TimeoutCycles+1) bits and never wraps.

Decomposition:
- Package ahb_ic_pkg holds:
  - trans_t enum (IDLE/BUSY/NONSEQ/SEQ).
  - ic_state_t enum (IDLE/DATA/ERR1/ERR2).
  - RESP_OKAY/RESP_ERROR constants.
- Sub-module ahb_ic_decoder: pure combinational region compare, producing sel_o, a hit flag and the hit index.
- FSM, watchdog, mux and error counter live in the top.

Test Plan:
- Decode and mux: NumSlave=4, BaseRegion=0. NONSEQ to 0x2000_0000 with slave 2 readyout=1 and rdata=0xDEAD_BEEF -> sel_o=4'b0100; next cycle rdata_o=0xDEAD_BEEF, resp_o=0, ready_o=1.
- Back-to-back with wait states: slave 1 then slave 3, with slave 1 stalling 3 cycles -> ready_o low for exactly 3 cycles; slave 3 data appears 1 cycle after slave 1 completes; no bubble.
- Unmapped access: NONSEQ to 0x9000_0000 -> cycle+1 ready_o=0/resp_o=1, cycle+2 ready_o=1/resp_o=1; err_cnt_o 0->1. IDLE to the same address -> zero-wait OKAY, no count.
- Timeout: TimeoutCycles=8, slave 0 holds readyout=0 -> timeout_o pulses after 8 stall cycles, then the ERR1/ERR2 sequence. A late readyout pulse from slave 0 has no effect on ready_o.
- Saturation and race: CntWidth=2 with 5 errors -> err_cnt_o stops at 3. Slave ready on the exact timeout cycle -> OKAY, timeout_o=0.
- Reset mid-DATA: assert rst_ni=0 during a stall -> next edge ready_o=1, resp_o=0, err_cnt_o=0, sel_o follows addr_i.
